distance_ascii_fmt: RTL and testbench

//   Converts each 16-bit distance sample (cm) from the hc_sr04 sensor block into an ASCII line

---
 rtl/distance_ascii_fmt.sv | 230 +++++++++++++++++++++++
 tb/tb_distance_ascii_fmt.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/distance_ascii_fmt.sv
// ---------------------------------------------------------------------------
// distance_ascii_fmt
//
// Turns each distance sample (cm) from the hc_sr04 block into an ASCII line
// such as "123cm\r\n". The line is streamed one byte at a time to the UART
// byte sender over a valid/ready handshake. A sample above MAX_CM becomes
// "---\r\n". The binary value is converted to BCD serially with
// double-dabble, one bit per clock, so no divide or modulo logic is needed.
//
// Ports
//   clk         system clock (same domain as hc_sr04)
//   rst         asynchronous active-high reset
//   dist_valid  one-cycle strobe qualifying dist_cm
//   dist_cm     unsigned distance sample
//   out_byte    ASCII byte offered downstream
//   out_valid   out_byte is valid and is held until accepted
//   out_ready   downstream accepts on an edge where out_valid && out_ready
//   busy        high whenever a line is being converted or emitted
//   dropped     one-cycle pulse when a strobe arrived while busy
// ---------------------------------------------------------------------------
module distance_ascii_fmt #(
    parameter int DIST_W     = 16,
    parameter int MAX_CM     = 400,
    parameter bit SEND_UNITS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_cm,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              dropped
);

    localparam int CNT_W = $clog2(DIST_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        EMIT_DIG,
        EMIT_C,
        EMIT_M,
        EMIT_CR,
        EMIT_LF,
        EMIT_DASH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DIST_W-1:0] bin;
    logic [19:0]       bcd;
    logic [19:0]       bcd_adj;
    logic [19:0]       bcd_next;
    logic [CNT_W-1:0]  conv_cnt;
    logic              conv_last;
    logic [2:0]        dig_idx;
    logic [1:0]        dash_cnt;
    logic [3:0]        cur_digit;
    logic              out_of_range;

    // Index of the first digit to print: the most significant non-zero
    // nibble, or the units digit (index 4) when the value is zero.
    function automatic logic [2:0] first_digit(input logic [19:0] v);
        if (v[19:16] != 4'd0) begin
            return 3'd0;
        end else if (v[15:12] != 4'd0) begin
            return 3'd1;
        end else if (v[11:8] != 4'd0) begin
            return 3'd2;
        end else if (v[7:4] != 4'd0) begin
            return 3'd3;
        end else begin
            return 3'd4;
        end
    endfunction

    assign out_of_range = (dist_cm > DIST_W'(MAX_CM));
    assign conv_last    = (conv_cnt == CNT_W'(DIST_W - 1));

    // Double-dabble adjust step: each nibble is corrected on its own with
    // 4-bit arithmetic, so a correction never carries into its neighbour.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The adjusted BCD shifts left and takes in the next binary MSB.
    assign bcd_next = (bcd_adj << 1) | {19'd0, bin[DIST_W-1]};

    // Digit index 0 is the ten-thousands digit and index 4 is the units.
    always_comb begin
        case (dig_idx)
            3'd0:    cur_digit = bcd[19:16];
            3'd1:    cur_digit = bcd[15:12];
            3'd2:    cur_digit = bcd[11:8];
            3'd3:    cur_digit = bcd[7:4];
            default: cur_digit = bcd[3:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. The outputs are decoded from the state
    // register, so reset clears them immediately. Each emit state holds its
    // byte until the handshake edge.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_byte   = 8'h00;
        case (state)
            IDLE: begin
                if (dist_valid) begin
                    state_next = out_of_range ? EMIT_DASH : CONV;
                end
            end
            CONV: begin
                if (conv_last) begin
                    state_next = EMIT_DIG;
                end
            end
            EMIT_DIG: begin
                out_valid = 1'b1;
                out_byte  = 8'h30 + {4'h0, cur_digit};
                if (out_ready && (dig_idx == 3'd4)) begin
                    state_next = SEND_UNITS ? EMIT_C : EMIT_CR;
                end
            end
            EMIT_C: begin
                out_valid = 1'b1;
                out_byte  = 8'h63;
                if (out_ready) begin
                    state_next = EMIT_M;
                end
            end
            EMIT_M: begin
                out_valid = 1'b1;
                out_byte  = 8'h6D;
                if (out_ready) begin
                    state_next = EMIT_CR;
                end
            end
            EMIT_CR: begin
                out_valid = 1'b1;
                out_byte  = 8'h0D;
                if (out_ready) begin
                    state_next = EMIT_LF;
                end
            end
            EMIT_LF: begin
                out_valid = 1'b1;
                out_byte  = 8'h0A;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            EMIT_DASH: begin
                out_valid = 1'b1;
                out_byte  = 8'h2D;
                if (out_ready && (dash_cnt == 2'd2)) begin
                    state_next = EMIT_CR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: sample capture, serial conversion, digit and dash counters.
    // On the last shift the leading-zero skip is taken from the value being
    // written, so the first digit is ready as soon as EMIT_DIG is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            conv_cnt <= '0;
            dig_idx  <= '0;
            dash_cnt <= '0;
            dropped  <= 1'b0;
        end else begin
            dropped <= dist_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (dist_valid) begin
                        bin      <= dist_cm;
                        bcd      <= '0;
                        conv_cnt <= '0;
                        dash_cnt <= '0;
                    end
                end
                CONV: begin
                    bin      <= bin << 1;
                    bcd      <= bcd_next;
                    conv_cnt <= conv_cnt + CNT_W'(1);
                    if (conv_last) begin
                        dig_idx <= first_digit(bcd_next);
                    end
                end
                EMIT_DIG: begin
                    if (out_ready && (dig_idx != 3'd4)) begin
                        dig_idx <= dig_idx + 3'd1;
                    end
                end
                EMIT_DASH: begin
                    if (out_ready) begin
                        dash_cnt <= dash_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_distance_ascii_fmt.sv
// ---------------------------------------------------------------------------
// tb_distance_ascii_fmt
//
// Drives distance samples into distance_ascii_fmt and compares the bytes it
// delivers with a reference model. The model builds each expected line
// directly from the decimal text of the sample. The bench checks the
// first-byte latency, the byte stream, how out_byte holds under
// backpressure, the dropped pulses and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_distance_ascii_fmt;

    logic        clk = 1'b0;
    logic        rst;
    logic        dist_valid;
    logic [15:0] dist_cm;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        dropped;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];
    int         expLat;
    int         dropCount  = 0;
    int         stabErr    = 0;
    logic       holdPending = 1'b0;
    logic [7:0] heldByte    = 8'h00;

    distance_ascii_fmt dut (
        .clk        (clk),
        .rst        (rst),
        .dist_valid (dist_valid),
        .dist_cm    (dist_cm),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    // Sampled on the falling edge: records the bytes that the next rising
    // edge accepts, counts dropped pulses and flags any change to a byte
    // that was offered but not yet taken.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                rxQ.push_back(out_byte);
            end
            if (dropped) begin
                dropCount++;
            end
            if (holdPending && (!out_valid || (out_byte != heldByte))) begin
                stabErr++;
            end
            holdPending = out_valid && !out_ready;
            heldByte    = out_byte;
        end else begin
            holdPending = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Reference line: the decimal text of the sample followed by "cm" and
    // CR LF, or three dashes for a sample above 400 cm.
    function automatic void modelLine(input int d);
        string s;
        expQ.delete();
        if (d > 400) begin
            repeat (3) expQ.push_back(8'h2D);
            expLat = 1;
        end else begin
            s = $sformatf("%0d", d);
            for (int i = 0; i < s.len(); i++) begin
                expQ.push_back(s[i]);
            end
            expQ.push_back(8'h63);
            expQ.push_back(8'h6D);
            expLat = 17;
        end
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
    endfunction

    // mode 0: out_ready held high; mode 1: five low cycles before each byte
    // is taken; mode 2: random out_ready. With inject set, extra strobes are
    // sent during conversion and while "m" is offered.
    task automatic applyStimulus(input int d, input int mode, input bit inject);
        int lat;
        int cyc;
        int rxStart;
        int dropStart;
        int stabStart;
        int lowCnt;
        int got;
        bit seen;
        bit mPulsed;

        modelLine(d);
        rxStart   = rxQ.size();
        dropStart = dropCount;
        stabStart = stabErr;

        out_ready  = (mode == 0);
        dist_cm    = d[15:0];
        dist_valid = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && (lat < 40)) begin
            @(posedge clk);
            #1;
            lat++;
            dist_valid = inject && (lat == 5);
            if (out_valid) begin
                seen = 1'b1;
            end
        end
        checkOutput($sformatf("first_valid_latency d=%0d", d), lat, expLat);

        cyc     = 0;
        lowCnt  = 0;
        mPulsed = 1'b0;
        while (busy && (cyc < 400)) begin
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if (out_valid && (lowCnt < 5)) begin
                        out_ready = 1'b0;
                        lowCnt++;
                    end else begin
                        out_ready = 1'b1;
                        if (out_valid) begin
                            lowCnt = 0;
                        end
                    end
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            dist_valid = 1'b0;
            if (inject && !mPulsed && out_valid && (out_byte == 8'h6D)) begin
                dist_valid = 1'b1;
                mPulsed    = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        dist_valid = 1'b0;
        out_ready  = 1'b1;
        checkOutput($sformatf("line_done_busy d=%0d", d), int'(busy), 0);

        repeat (inject ? 25 : 3) @(posedge clk);
        #1;
        checkOutput($sformatf("byte_count d=%0d", d), rxQ.size() - rxStart, expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            got = (rxStart + i < rxQ.size()) ? int'(rxQ[rxStart + i]) : 'h100;
            checkOutput($sformatf("byte[%0d] d=%0d", i, d), got, int'(expQ[i]));
        end
        checkOutput($sformatf("hold_stable_errors d=%0d", d), stabErr - stabStart, 0);
        checkOutput($sformatf("dropped_pulses d=%0d", d), dropCount - dropStart, inject ? 2 : 0);
    endtask

    initial begin
        int  cyc;
        int  r;
        int  d;
        bit  found;

        rst        = 1'b1;
        dist_valid = 1'b0;
        dist_cm    = 16'd0;
        out_ready  = 1'b1;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_byte", int'(out_byte), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_dropped", int'(dropped), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 1'b0);
        applyStimulus(123, 0, 1'b0);
        applyStimulus(400, 0, 1'b0);
        applyStimulus(7, 0, 1'b0);
        applyStimulus(401, 0, 1'b0);
        applyStimulus(56, 1, 1'b0);
        applyStimulus(123, 0, 1'b1);

        // Reset while the "2" of "123" is on offer.
        dist_cm    = 16'd123;
        dist_valid = 1'b1;
        @(posedge clk);
        #1;
        dist_valid = 1'b0;
        found = 1'b0;
        cyc   = 0;
        while (!found && (cyc < 60)) begin
            if (out_valid && (out_byte == 8'h32)) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput("offer_digit2", int'(found), 1);
        rst = 1'b1;
        #1;
        checkOutput("midline_reset_out_valid", int'(out_valid), 0);
        checkOutput("midline_reset_busy", int'(busy), 0);
        checkOutput("midline_reset_out_byte", int'(out_byte), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("idle_after_reset_busy", int'(busy), 0);
        applyStimulus(9, 0, 1'b0);

        applyStimulus(65535, 2, 1'b0);
        for (int k = 0; k < 25; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                d = int'($urandom_range(401, 65535));
            end else if (r == 1) begin
                d = int'($urandom_range(395, 405));
            end else begin
                d = int'($urandom_range(0, 400));
            end
            applyStimulus(d, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
